mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequencer between the MEM pipeline stage and the word-wide data_mem block.
//  Turns byte/halfword/word loads and stores into data_mem read/write cycles:
//  word stores go direct, sub-word stores use read-modify-write, and loads are
//  sign- or zero-extended. Holds o_busy while a transfer is in flight.
//  Rejects misaligned accesses with no memory cycle.
// PARAMETERS
//  B   32  data width; only 32 is supported (4 little-endian byte lanes)
//  W   5   data_mem word-address bits; byte address is W+2 bits
// PORTS
//  i_clk         in   1     clock, all state updates on rising edge
//  i_rst_n       in   1     asynchronous active-low reset
//  i_req         in   1     access request, sampled only when o_busy=0
//  i_we          in   1     1=store, 0=load
//  i_size        in   2     00 byte, 01 half, 10 word, 11 reserved
//  i_unsigned    in   1     load: 1=zero-extend, 0=sign-extend
//  i_addr        in   W+2   byte address
//  i_wdata       in   B     store data (right-justified for byte/half)
//  o_busy        out  1     stall to pipeline; high whenever state!=IDLE
//  o_done        out  1     one-cycle pulse: transfer finished
//  o_err         out  1     qualifies o_done: misaligned/reserved size
//  o_rdata       out  B     extended load result; holds until next good load
//  o_mem_read    out  1     to data_mem i_mem_read
//  o_mem_write   out  1     to data_mem i_mem_write
//  o_mem_addr    out  W     to data_mem i_addr (= latched i_addr[W+1:2])
//  o_mem_wdata   out  B     to data_mem i_data
//  i_mem_rdata   in   B     from data_mem o_data (registered, 1-cycle latency)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; all outputs 0.
//  - All outputs are registered. Request fields are latched on acceptance.
//  - Accept: edge where state=IDLE and i_req=1. Requests are ignored while busy.
//  - Byte lane: k=addr[1:0]; lane k occupies bits [8k+7:8k]. Half uses lanes
//    2h..2h+1, where h=addr[1].
//  - Error: size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
//    IDLE->DONE with o_err=1. No mem strobe; o_rdata unchanged.
//  - FSM states: IDLE, RD, CAP, RMW_RD, MERGE, WR, DONE.
//  - Word store: IDLE->WR->DONE. WR: o_mem_write=1, o_mem_wdata=wdata.
//    o_done is 2 cycles after the accept edge.
//  - Load: IDLE->RD->CAP->DONE.
//    RD: o_mem_read=1 (one cycle only).
//    CAP: i_mem_rdata is valid; extract the lane, extend per i_unsigned,
//    register into o_rdata.
//    DONE: o_done=1 and o_rdata is valid. Latency 3 cycles.
//  - Sub-word store: IDLE->RMW_RD->MERGE->WR->DONE.
//    RMW_RD: o_mem_read=1.
//    MERGE: replace only the target lane(s) of i_mem_rdata with the low bits
//    of wdata, then register into o_mem_wdata.
//    WR: write.
//    Latency 4 cycles. Untouched lanes are preserved bit-exact.
//  - DONE->IDLE unconditionally, so back-to-back requests see 1 idle cycle.
//  - o_mem_read and o_mem_write are never high together. The address is stable
//    across the whole RMW sequence.
//  - Reset during WR, before its edge: no write is committed.
//    Reset during MERGE: memory unchanged.
//  - Top byte address wraps naturally (word index is W bits). No saturation.
// TESTING
//  1 Word store 0xDEADBEEF @0x08, then word load @0x08
//    -> mem[2]=DEADBEEF; o_done 3 cycles after accept; o_rdata=DEADBEEF.
//  2 mem[1]=0x11223344; byte store 0xAA @0x06
//    -> mem[1]=0x11AA3344; o_busy high 4 cycles.
//  3 mem[3]=0x80F07F01; signed byte load @0x0D -> 0x0000007F;
//    signed half load @0x0E -> 0xFFFF80F0; unsigned byte load @0x0F -> 0x80.
//  4 Half store @0x05, then word load @0x02
//    -> each gives o_done+o_err one cycle after accept; no strobes;
//    memory and o_rdata unchanged.
//  5 Pulse i_rst_n low during WR of a byte store
//    -> all outputs 0 immediately; target word unchanged; next request is
//    served normally.
//  6 i_req held high across busy
//    -> exactly one access per accept; no strobe overlap; accesses separated
//    by the DONE/IDLE gap.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences byte/half/word loads and stores from the MEM
// stage onto a word-wide, registered-read data memory. Sub-word stores use
// read-modify-write; loads are sign/zero extended; misaligned or reserved
// accesses finish immediately with o_err and no memory cycle.
module mem_access_ctrl #(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_req,
    input  logic           i_we,
    input  logic [1:0]     i_size,
    input  logic           i_unsigned,
    input  logic [W+1:0]   i_addr,
    input  logic [B-1:0]   i_wdata,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic [B-1:0]   o_rdata,
    output logic           o_mem_read,
    output logic           o_mem_write,
    output logic [W-1:0]   o_mem_addr,
    output logic [B-1:0]   o_mem_wdata,
    input  logic [B-1:0]   i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        RMW_RD,
        MERGE,
        WR,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;

    logic         we_q;
    logic [1:0]   size_q;
    logic         uns_q;
    logic [1:0]   lane_q;
    logic [B-1:0] wdata_q;

    logic         accept;
    logic         bad;
    logic [B-1:0] shifted;
    logic [B-1:0] extended;
    logic [B-1:0] merged;

    // Request qualification: acceptance and alignment/size error detection
    always_comb begin
        accept = (state == IDLE) && i_req;
        bad    = (i_size == 2'b11) ||
                 ((i_size == 2'b01) && i_addr[0]) ||
                 ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));
    end

    // Next-state logic for the access sequencer
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad)
                        state_next = DONE;
                    else if (i_we && (i_size == 2'b10))
                        state_next = WR;
                    else if (i_we)
                        state_next = RMW_RD;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = CAP;
            CAP:     state_next = DONE;
            RMW_RD:  state_next = MERGE;
            MERGE:   state_next = WR;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load lane extraction and extension from the returned memory word
    always_comb begin
        shifted  = i_mem_rdata >> {lane_q, 3'b000};
        extended = i_mem_rdata;
        case (size_q)
            2'b00:   extended = {{(B-8){~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   extended = {{(B-16){~uns_q & shifted[15]}}, shifted[15:0]};
            default: extended = i_mem_rdata;
        endcase
    end

    // Store merge: overwrite only the target lane(s) of the old word
    always_comb begin
        merged = i_mem_rdata;
        case (size_q)
            2'b00:   merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Registered outputs and latched request fields; strobes are decoded
    // from the next state so they line up with the state they belong to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_rdata     <= '0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
        end else begin
            o_busy      <= (state_next != IDLE);
            o_done      <= (state_next == DONE);
            o_err       <= accept && bad;
            o_mem_read  <= (state_next == RD) || (state_next == RMW_RD);
            o_mem_write <= (state_next == WR);
            if (accept) begin
                we_q       <= i_we;
                size_q     <= i_size;
                uns_q      <= i_unsigned;
                lane_q     <= i_addr[1:0];
                wdata_q    <= i_wdata;
                o_mem_addr <= i_addr[W+1:2];
                if (!bad && i_we && (i_size == 2'b10))
                    o_mem_wdata <= i_wdata;
            end
            if (state == MERGE)
                o_mem_wdata <= merged;
            if (state == CAP)
                o_rdata <= extended;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a registered-read word memory model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_read, mem_write;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:31];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int n_assert = 0;
    int n_fail = 0;
    int overlap = 0;
    int lat, busy_cnt, rd_cnt, wr_cnt, done_cnt;
    logic err_seen;

    mem_access_ctrl #(.B(32), .W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
        .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: one-cycle registered read, write on the strobe edge
    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else begin
            if (mem_read)  mem_rdata <= mem[mem_addr];
            if (mem_write) mem[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk)
        if (mem_read && mem_write) overlap++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Issue one request and measure until o_done (bounded to 10 cycles)
    task automatic run(input logic w, input logic [1:0] s, input logic u,
                       input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        lat = 0; busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; err_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (busy)      busy_cnt++;
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if (done) begin
                lat = k;
                err_seen = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'h0);
        chk("rst_addr", {27'b0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: word store then word load
        run(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF);
        chk("t1_st_lat", lat, 2);
        chk("t1_st_wr", wr_cnt, 1);
        chk("t1_st_rd", rd_cnt, 0);
        chk("t1_st_mem", mem[2], 32'hDEADBEEF);
        run(1'b0, 2'b10, 1'b0, 7'h08, 32'h0);
        chk("t1_ld_lat", lat, 3);
        chk("t1_ld_rd", rd_cnt, 1);
        chk("t1_ld_rdata", rdata, 32'hDEADBEEF);
        chk("t1_ld_err", {31'b0, err_seen}, 32'h0);

        // 2: sub-word stores via read-modify-write
        preload(5'd1, 32'h11223344);
        run(1'b1, 2'b00, 1'b0, 7'h06, 32'h000000AA);
        chk("t2_b_lat", lat, 4);
        chk("t2_b_busy", busy_cnt, 4);
        chk("t2_b_rd", rd_cnt, 1);
        chk("t2_b_wr", wr_cnt, 1);
        chk("t2_b_mem", mem[1], 32'h11AA3344);
        preload(5'd7, 32'h12345678);
        run(1'b1, 2'b01, 1'b0, 7'h1E, 32'hFFFFBEEF);
        chk("t2_h_mem", mem[7], 32'hBEEF5678);
        run(1'b1, 2'b10, 1'b0, 7'h7C, 32'hCAFEF00D);
        chk("t2_top_mem", mem[31], 32'hCAFEF00D);

        // 3: extended loads
        preload(5'd3, 32'h80F07F01);
        run(1'b0, 2'b00, 1'b0, 7'h0D, 32'h0);
        chk("t3_sb_0d", rdata, 32'h0000007F);
        run(1'b0, 2'b01, 1'b0, 7'h0E, 32'h0);
        chk("t3_sh_0e", rdata, 32'hFFFF80F0);
        run(1'b0, 2'b01, 1'b1, 7'h0C, 32'h0);
        chk("t3_uh_0c", rdata, 32'h00007F01);
        run(1'b0, 2'b00, 1'b0, 7'h0F, 32'h0);
        chk("t3_sb_0f", rdata, 32'hFFFFFF80);
        run(1'b0, 2'b00, 1'b1, 7'h0F, 32'h0);
        chk("t3_ub_0f", rdata, 32'h00000080);

        // 4: rejected accesses
        run(1'b1, 2'b01, 1'b0, 7'h05, 32'h00005555);
        chk("t4_h_lat", lat, 1);
        chk("t4_h_err", {31'b0, err_seen}, 32'h1);
        chk("t4_h_strobes", rd_cnt + wr_cnt, 0);
        chk("t4_h_mem", mem[1], 32'h11AA3344);
        chk("t4_h_rdata", rdata, 32'h00000080);
        run(1'b0, 2'b10, 1'b0, 7'h02, 32'h0);
        chk("t4_w_lat", lat, 1);
        chk("t4_w_err", {31'b0, err_seen}, 32'h1);
        chk("t4_w_strobes", rd_cnt + wr_cnt, 0);
        chk("t4_w_rdata", rdata, 32'h00000080);
        run(1'b0, 2'b11, 1'b0, 7'h00, 32'h0);
        chk("t4_rsv_err", {31'b0, err_seen}, 32'h1);
        chk("t4_rsv_strobes", rd_cnt + wr_cnt, 0);

        // 5: reset asserted during the write of a byte store
        preload(5'd4, 32'h55667788);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 7'h11; wdata = 32'h99;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_wr", {31'b0, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy0", {31'b0, busy}, 32'h0);
        chk("t5_strobes0", {30'b0, mem_read, mem_write}, 32'h0);
        chk("t5_outs0", {29'b0, done, err, |mem_addr} | rdata | mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_mem", mem[4], 32'h55667788);
        run(1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
        chk("t5_after_lat", lat, 3);
        chk("t5_after_rdata", rdata, 32'h55667788);

        // 6: request held high across busy
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 7'h08;
        done_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done)      done_cnt++;
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if (k == 4) chk("t6_gap1", {31'b0, busy}, 32'h0);
            if (k == 8) begin
                chk("t6_gap2", {31'b0, busy}, 32'h0);
                req = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done)     done_cnt++;
            if (mem_read) rd_cnt++;
        end
        chk("t6_dones", done_cnt, 2);
        chk("t6_reads", rd_cnt, 2);
        chk("t6_writes", wr_cnt, 0);
        chk("t6_rdata", rdata, 32'hDEADBEEF);
        chk("no_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
